// File: rtl/sparc_pkg.sv
// rtl/sparc_pkg.sv - shared SPARC integer condition code definitions
package sparc_pkg;

  // Bit positions of the flags inside the 4-bit icc vector {N,Z,V,C}
  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  // Bicc cond field encodings, instr[28:25]
  localparam logic [3:0] COND_BN   = 4'b0000;
  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BLE  = 4'b0010;
  localparam logic [3:0] COND_BL   = 4'b0011;
  localparam logic [3:0] COND_BLEU = 4'b0100;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;
  localparam logic [3:0] COND_BNE  = 4'b1001;
  localparam logic [3:0] COND_BG   = 4'b1010;
  localparam logic [3:0] COND_BGE  = 4'b1011;
  localparam logic [3:0] COND_BGU  = 4'b1100;
  localparam logic [3:0] COND_BCC  = 4'b1101;
  localparam logic [3:0] COND_BPOS = 4'b1110;
  localparam logic [3:0] COND_BVC  = 4'b1111;

  // Branch sequencing state: no branch pending, delay slot executing,
  // delay slot annulled
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DS    = 2'b01,
    ANNUL = 2'b10
  } br_state_e;

endpackage

// File: rtl/icc_cond_eval.sv
// rtl/icc_cond_eval.sv - combinational Bicc/Ticc condition evaluator
module icc_cond_eval
  import sparc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       true
);

  logic n, z, v, c;
  logic base;

  assign n = flags[ICC_N];
  assign z = flags[ICC_Z];
  assign v = flags[ICC_V];
  assign c = flags[ICC_C];

  // Low three cond bits select the test; cond[3] inverts it, which turns
  // "never" into "always" and each test into its complement.
  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      3'b000:  base = 1'b0;
      3'b001:  base = z;
      3'b010:  base = z | (n ^ v);
      3'b011:  base = n ^ v;
      3'b100:  base = c | z;
      3'b101:  base = c;
      3'b110:  base = n;
      3'b111:  base = v;
      default: base = 1'b0;
    endcase
  end

  assign true = cond[3] ? ~base : base;

endmodule

// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - Bicc condition evaluation, delay-slot control and counters
module branch_cond_unit
  import sparc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [3:0]       cond,
  input  logic             annul,
  input  logic [3:0]       icc,
  input  logic             icc_wr_en,
  input  logic [3:0]       icc_wr_data,
  output logic             taken,
  output logic             squash_ds,
  output logic             in_ds,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  br_state_e  state, state_next;
  logic [3:0] eff_flags;
  logic       cond_true;
  logic       accept;
  logic       go_annul;

  // A PSR write in this same cycle wins over the stored flags
  assign eff_flags = icc_wr_en ? icc_wr_data : icc;

  icc_cond_eval u_eval (
    .cond  (cond),
    .flags (eff_flags),
    .true  (cond_true)
  );

  // An instruction sitting in an annulled slot is not a real branch
  assign accept   = br_valid & ~stall & (state != ANNUL);
  assign go_annul = annul & (~cond_true | (cond == COND_BA));

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: track whether the instruction following a branch runs or is squashed
  always_comb begin
    state_next = state;
    if (!stall) begin
      case (state)
        IDLE:    state_next = accept ? (go_annul ? ANNUL : DS) : IDLE;
        DS:      state_next = accept ? (go_annul ? ANNUL : DS) : IDLE;
        ANNUL:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign in_ds     = (state != IDLE);
  assign squash_ds = (state == ANNUL);

  // Taken pulse aligned with the delay slot; held through a stall
  always_ff @(posedge clk) begin
    if (clr)         taken <= 1'b0;
    else if (!stall) taken <= accept & cond_true;
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (clr) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      if (accept && br_cnt != CNT_MAX)
        br_cnt <= br_cnt + CNT_W'(1);
      if (accept && cond_true && taken_cnt != CNT_MAX)
        taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// tb/tb_branch_cond_unit.sv - scoreboard bench for branch_cond_unit
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        clr, stall, br_valid, annul, icc_wr_en;
  logic [3:0]  cond, icc, icc_wr_data;
  logic        taken, squash_ds, in_ds;
  logic [15:0] br_cnt, taken_cnt;
  logic        taken4, squash4, in_ds4;
  logic [3:0]  br_cnt4, taken_cnt4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic tk;
    logic sq;
    logic ds;
  } exp_t;

  exp_t sb_q[$];

  int unsigned m_br, m_tk, m_br4, m_tk4;
  int          table_true;

  always #5 clk = ~clk;

  branch_cond_unit #(.CNT_W(16)) dut (
    .clk(clk), .clr(clr), .stall(stall), .br_valid(br_valid), .cond(cond),
    .annul(annul), .icc(icc), .icc_wr_en(icc_wr_en), .icc_wr_data(icc_wr_data),
    .taken(taken), .squash_ds(squash_ds), .in_ds(in_ds),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  branch_cond_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .clr(clr), .stall(stall), .br_valid(br_valid), .cond(cond),
    .annul(annul), .icc(icc), .icc_wr_en(icc_wr_en), .icc_wr_data(icc_wr_data),
    .taken(taken4), .squash_ds(squash4), .in_ds(in_ds4),
    .br_cnt(br_cnt4), .taken_cnt(taken_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference Bicc table written out per mnemonic
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cc)
      4'h0: return 1'b0;
      4'h1: return z;
      4'h2: return z || (n != v);
      4'h3: return n != v;
      4'h4: return c || z;
      4'h5: return c;
      4'h6: return n;
      4'h7: return v;
      4'h8: return 1'b1;
      4'h9: return !z;
      4'hA: return !z && (n == v);
      4'hB: return n == v;
      4'hC: return !c && !z;
      4'hD: return !c;
      4'hE: return !n;
      default: return !v;
    endcase
  endfunction

  // Drive one cycle; expected outputs and acceptance come from the caller
  task automatic step(input logic bv, input logic [3:0] cc, input logic an,
                      input logic [3:0] flags, input logic wen, input logic [3:0] wdata,
                      input logic e_tk, input logic e_sq, input logic e_ds,
                      input logic e_acc, input string tag);
    exp_t e;
    br_valid = bv; cond = cc; annul = an; icc = flags;
    icc_wr_en = wen; icc_wr_data = wdata;
    e.tk = e_tk; e.sq = e_sq; e.ds = e_ds;
    sb_q.push_back(e);
    if (clr) begin
      m_br = 0; m_tk = 0; m_br4 = 0; m_tk4 = 0;
    end else if (e_acc) begin
      if (m_br < 65535) m_br++;
      if (m_br4 < 15) m_br4++;
      if (e_tk) begin
        if (m_tk < 65535) m_tk++;
        if (m_tk4 < 15) m_tk4++;
      end
    end
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_taken"}, {31'd0, taken}, {31'd0, e.tk});
      check({tag, "_squash"}, {31'd0, squash_ds}, {31'd0, e.sq});
      check({tag, "_in_ds"}, {31'd0, in_ds}, {31'd0, e.ds});
    end
    check({tag, "_br_cnt"}, {16'd0, br_cnt}, m_br);
    check({tag, "_taken_cnt"}, {16'd0, taken_cnt}, m_tk);
    check({tag, "_br_cnt4"}, {28'd0, br_cnt4}, m_br4);
    check({tag, "_taken_cnt4"}, {28'd0, taken_cnt4}, m_tk4);
  endtask

  task automatic idle(input logic e_ds_prev_sq, input string tag);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    m_br = 0; m_tk = 0; m_br4 = 0; m_tk4 = 0;
    table_true = 0;
    clr = 1'b1; stall = 1'b0; br_valid = 1'b1; cond = 4'h8; annul = 1'b1;
    icc = 4'h0; icc_wr_en = 1'b0; icc_wr_data = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_taken", {31'd0, taken}, 0);
    check("rst_squash", {31'd0, squash_ds}, 0);
    check("rst_in_ds", {31'd0, in_ds}, 0);
    check("rst_br_cnt", {16'd0, br_cnt}, 0);
    check("rst_taken_cnt", {16'd0, taken_cnt}, 0);
    clr = 1'b0;

    // Full table sweep, back-to-back branches (each sits in the previous delay slot)
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        logic r;
        r = ref_cond(4'(c), 4'(f));
        if (r) table_true++;
        step(1'b1, 4'(c), 1'b0, 4'(f), 1'b0, 4'h0, r, 1'b0, 1'b1, 1'b1, "sweep");
      end
    end
    idle(1'b0, "sweep_end");
    check("sweep_br_cnt", {16'd0, br_cnt}, 256);
    check("sweep_taken_cnt", {16'd0, taken_cnt}, 128);
    check("sweep_model_true", {16'd0, taken_cnt}, table_true);

    // Annul cases with Z=1
    step(1'b1, 4'h1, 1'b1, 4'b0100, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, "be_a");
    idle(1'b0, "be_a_idle");
    step(1'b1, 4'h9, 1'b1, 4'b0100, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, "bne_a");
    idle(1'b0, "bne_a_idle");
    step(1'b1, 4'h8, 1'b1, 4'b0100, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, "ba_a");
    idle(1'b0, "ba_a_idle");
    step(1'b1, 4'h0, 1'b1, 4'b0100, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, "bn_a");
    idle(1'b0, "bn_a_idle");

    // Same-cycle PSR write forwarding
    step(1'b1, 4'h1, 1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, "fwd_on");
    idle(1'b0, "fwd_on_idle");
    step(1'b1, 4'h1, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, "fwd_off");
    idle(1'b0, "fwd_off_idle");
    step(1'b1, 4'h9, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, "fwd_over");
    idle(1'b0, "fwd_over_idle");

    // DCTI couple: BA then BE in its delay slot
    step(1'b1, 4'h8, 1'b0, 4'b0100, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, "dcti_ba");
    step(1'b1, 4'h1, 1'b0, 4'b0100, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, "dcti_be");
    idle(1'b0, "dcti_idle");

    // Branch in an annulled slot is ignored
    step(1'b1, 4'h9, 1'b1, 4'b0100, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, "ann_bne");
    step(1'b1, 4'h8, 1'b0, 4'b0100, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "ann_ignored");
    idle(1'b0, "ann_idle");

    // Stall holds a taken pulse and ignores inputs
    step(1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, "stall_ba");
    stall = 1'b1;
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'(i + 1), 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, "stall_hold");
    stall = 1'b0;
    idle(1'b0, "stall_release");

    // Reset while in ANNUL, with stall and a branch also present
    step(1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, "pre_clr_ba_a");
    clr = 1'b1; stall = 1'b1;
    step(1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "clr_annul");
    clr = 1'b0; stall = 1'b0;

    // Saturation: 20 BA on both counter widths
    for (int i = 0; i < 20; i++)
      step(1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, "sat");
    check("sat_br_cnt4", {28'd0, br_cnt4}, 15);
    check("sat_taken_cnt4", {28'd0, taken_cnt4}, 15);
    check("sat_br_cnt16", {16'd0, br_cnt}, 20);
    idle(1'b0, "sat_idle");
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Consumer side of the processor status flags. Samples the integer condition codes held in the PSR, evaluates SPARC Bicc conditions for branches in decode, and drives the branch-taken and delay-slot-annul decisions into fetch. It also forwards a same-cycle PSR write so that a flag-setting instruction immediately ahead of the branch is honoured. Saturating branch/taken counters are provided for performance debug.

## Interface
- CNT_W, 16: width of each performance counter.
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  synchronous, active-high reset.
- stall  in  1  pipeline hold; freezes all state, outputs and counters.
- br_valid  in  1  Bicc instruction present in decode.
- cond  in  4  Bicc cond field, instr[28:25].
- annul  in  1  Bicc a bit, instr[29].
- icc  in  4  current PSR flags {N,Z,V,C}.
- icc_wr_en  in  1  PSR is being written this cycle.
- icc_wr_data  in  4  flags being written this cycle {N,Z,V,C}.
- taken  out  1  registered one-cycle pulse: the branch accepted last cycle is taken.
- squash_ds  out  1  instruction now in decode (the delay slot) is annulled.
- in_ds  out  1  instruction now in decode is a delay slot.
- br_cnt  out  CNT_W  accepted branches, saturating.
- taken_cnt  out  CNT_W  taken branches, saturating.

## Operation
- Effective flags: icc_wr_data when icc_wr_en=1, else icc.
- Conditions, with N,Z,V,C taken from the effective flags: 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V; 0100 C|Z; 0101 C; 0110 N; 0111 V; 1000 always; 1001–1111 are the complements of 0001–0111 respectively.
- Acceptance: a branch is accepted when br_valid=1, stall=0 and state≠ANNUL. While state=ANNUL, br_valid is ignored because that instruction is annulled.
- FSM, 2-bit state, updated only when stall=0:
  - IDLE: on accept, go to DS or ANNUL per the annul rule; otherwise stay in IDLE.
  - DS: the delay slot executes. If that slot is itself an accepted branch (DCTI couple), it is evaluated and the FSM goes to DS or ANNUL per the annul rule; otherwise go to IDLE.
  - ANNUL: the delay slot is squashed; go to IDLE.
- Annul rule: enter ANNUL if annul=1 and (condition false, or cond=1000). Otherwise enter DS. BN with annul=1 is never taken, so it enters ANNUL.
- Outputs:
  - in_ds = (state≠IDLE).
  - squash_ds = (state==ANNUL).
  - taken is a register, loaded with (accept & cond_true) on each non-stalled cycle.
- Counters: br_cnt increments by 1 on accept; taken_cnt increments on accept & cond_true. Each stops at 2^CNT_W−1.
- Reset values: state=IDLE; taken, squash_ds, in_ds = 0; br_cnt, taken_cnt = 0.

## Timing
- Latency: a branch accepted in cycle N produces taken, in_ds and squash_ds in cycle N+1, aligned with the delay slot sitting in decode.
- Stall: all registers hold, so a taken pulse stays high for the full duration of the stall. Inputs are not sampled during stall.
- Simultaneous events:
  - clr overrides stall and accept.
  - icc_wr_en takes priority over icc in the same cycle as br_valid.
- Reset mid-operation: clr while in DS or ANNUL returns to IDLE next cycle. No pending squash survives the reset.
- Counter saturation: at the maximum value, a further increment leaves the counter unchanged. There is no wrap to 0.

## Structure
- The shared package `sparc_pkg` holds:
  - the icc bit-index constants ICC_N=3, ICC_Z=2, ICC_V=1, ICC_C=0;
  - the Bicc cond encodings (COND_BN … COND_BVC);
  - the FSM state enum {IDLE, DS, ANNUL}.
- One combinational sub-module, `icc_cond_eval` (inputs cond and flags; output true), is reused later by Ticc.
- FSM, taken register and counters stay in the top module.

## Test plan
- Table sweep: for all 16 cond values × all 16 flag values with annul=0, taken in the next cycle equals the table entry. br_cnt=256, and taken_cnt equals the number of true entries (128).
- Annul cases: with icc=0100 (Z=1):
  - BE annul=1 gives taken=1, squash_ds=0.
  - BNE annul=1 gives taken=0, squash_ds=1.
  - BA annul=1 gives taken=1, squash_ds=1.
- Forwarding: icc=0000, icc_wr_en=1, icc_wr_data=0100, BE in the same cycle gives taken=1. With icc_wr_en=0, taken=0.
- DCTI and annulled slot:
  - BA annul=0, then BE in the delay slot with Z=1 gives two consecutive taken pulses.
  - A branch presented while squash_ds=1 is ignored: br_cnt does not change.
- Stall/reset: assert stall for 3 cycles after an accepted taken branch; taken stays 1 for all 3 cycles. Then assert clr while in ANNUL: next cycle state=IDLE and all outputs are 0.
- Saturation with CNT_W=4: 20 accepted BA branches give br_cnt=taken_cnt=15.
